ftd_psnm_gate: RTL and testbench
================================

// Module: ftd_psnm_gate
// PURPOSE
//  Parametrised final-trigger output stage placed after the FTD logic bit vector.
//  - Applies a per-bit mask, then a per-bit prescale (PSNM).
//  - Arbitrates live time through a request/ack handshake to the trigger distributor.
//  - Enforces a programmable dead time and keeps accepted/lost scalers.
//  Generalises the fixed 13-bit FTD output to N_BIT channels with sequential gating.
// PARAMETERS
//  N_BIT    16  number of FTD bits handled
//  PS_W     10  width of each per-bit prescale factor/counter
//  DEAD_W    8  width of dead-time setting/counter
//  SCL_W    32  width of N_ACC / N_LOST scalers
// PORTS
//  CLK       in   1            system clock, all logic on posedge
//  RST_N     in   1            asynchronous active-low reset
//  FTD_IN    in   N_BIT        raw FTD bits
//  FTD_VLD   in   1            FTD_IN valid this cycle
//  MASK      in   N_BIT        1 = bit enabled
//  PSCALE    in   N_BIT*PS_W   bit i at [i*PS_W+:PS_W]; 0 = never pass, k = pass 1 of k
//  DEADTIME  in   DEAD_W       dead cycles after each ack
//  BUSY      in   1            downstream busy; blocks acceptance
//  CLR       in   1            sync clear of scalers and prescale counters
//  TRG_ACK   in   1            distributor accepts current request
//  TRG_REQ   out  1            trigger request, held until acked
//  PSNM      out  N_BIT        prescaled bits of requested event, stable while TRG_REQ
//  LIVE      out  1            state==IDLE & !BUSY (combinational from regs + BUSY)
//  N_ACC     out  SCL_W        accepted triggers, saturating
//  N_LOST    out  SCL_W        masked raw events arriving while not live, saturating
// BEHAVIOUR
//  Reset (async, RST_N=0)
//  - TRG_REQ=0, PSNM=0, N_ACC=0, N_LOST=0.
//  - All prescale counters=0, dead counter=0, state=IDLE, input reg=0.
//  Stage 1 (input register)
//  - ftdr <= FTD_IN & MASK & {N_BIT{FTD_VLD}}.
//  Stage 2 (prescale), only when LIVE
//  - per bit i with ftdr[i]=1 and PSCALE_i!=0:
//    - if c[i] >= PSCALE_i-1: pass[i]=1, c[i]<=0.
//    - else c[i]<=c[i]+1.
//  - the >= handles PSCALE lowered below the current count: pass and reset.
//  - Counters hold when not live, or when PSCALE_i=0.
//  FSM
//  - IDLE -> REQ when LIVE & |pass.
//    - Register PSNM<=pass and TRG_REQ<=1.
//    - N_ACC+1.
//  - REQ: TRG_REQ and PSNM hold until TRG_ACK=1 is sampled.
//    - On ack: TRG_REQ<=0.
//    - If DEADTIME==0, go to IDLE; else go to DEAD with dcnt<=DEADTIME.
//  - DEAD: dcnt decrements; leave to IDLE when dcnt==1 (exactly DEADTIME dead cycles).
//  - TRG_ACK outside REQ is ignored.
//  - DEADTIME is sampled only on ack.
//  Latency
//  - FTD_IN at edge t -> TRG_REQ high after edge t+2.
//  - Earliest re-accept: 1 cycle after ack with DEADTIME=0.
//  Lost accounting
//  - N_LOST+1 on any cycle with |ftdr & !LIVE (one count per cycle, not per bit).
//  - Masked-off bits are never counted.
//  Scalers and CLR
//  - Scalers saturate at all-ones; no wrap.
//  - CLR zeroes N_ACC, N_LOST and all c[i].
//  - CLR wins over a same-cycle increment (result 0).
//  - CLR does not affect state, TRG_REQ, PSNM or dcnt.
// TESTING
//  T1 prescale
//  - Stimulus: PSCALE0=3, MASK=1, DEADTIME=0, ack 1 cycle after req; 9 isolated bit0 pulses, 10 cycles apart.
//  - Required: 3 requests, on pulses 3/6/9, each with PSNM=0x0001; N_ACC=3, N_LOST=0.
//  T2 masking
//  - Stimulus: MASK=0, FTD_IN=all ones for 50 cycles.
//  - Required: TRG_REQ never set; N_ACC=0, N_LOST=0.
//  T3 dead time
//  - Stimulus: DEADTIME=5, PSCALE=1; pulse at t, immediate ack; second pulse 3 cycles after ack.
//  - Required: second pulse gives no request and N_LOST=1; pulse at ack+6 is accepted.
//  T4 held handshake
//  - Stimulus: ack withheld 20 cycles while bit2 pulses 4 times.
//  - Required: TRG_REQ/PSNM stable for all 20 cycles; N_LOST=4; c[2] unchanged.
//  T5 async reset
//  - Stimulus: RST_N low mid-REQ, between clock edges.
//  - Required: TRG_REQ=0 and scalers=0 immediately; after release, first pulse with PSCALE=1 accepted at +2 edges.
//  T6 clear collision
//  - Stimulus: CLR asserted in the IDLE->REQ cycle.
//  - Required: TRG_REQ=1 but N_ACC=0 afterwards; N_ACC saturates at 2^SCL_W-1 when preloaded (small SCL_W build).

Source files
------------

// File: rtl/ftd_psnm_gate.sv
`default_nettype none
// ============================================================================
//  Module      : ftd_psnm_gate
//  Description : Final-trigger output stage for the FTD bit vector. Masks and
//                prescales each bit, raises a held request/ack trigger to the
//                distributor, enforces a programmable dead time and keeps
//                saturating accepted/lost scalers.
//  Revision    : 1.0 - initial release
// ============================================================================
module ftd_psnm_gate #(
    parameter int N_BIT  = 16,
    parameter int PS_W   = 10,
    parameter int DEAD_W = 8,
    parameter int SCL_W  = 32
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [N_BIT-1:0]        FTD_IN,
    input  logic                    FTD_VLD,
    input  logic [N_BIT-1:0]        MASK,
    input  logic [N_BIT*PS_W-1:0]   PSCALE,
    input  logic [DEAD_W-1:0]       DEADTIME,
    input  logic                    BUSY,
    input  logic                    CLR,
    input  logic                    TRG_ACK,
    output logic                    TRG_REQ,
    output logic [N_BIT-1:0]        PSNM,
    output logic                    LIVE,
    output logic [SCL_W-1:0]        N_ACC,
    output logic [SCL_W-1:0]        N_LOST
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    logic [1:0]        r_state;
    logic [DEAD_W-1:0] r_dcnt;
    logic [N_BIT-1:0]  r_ftdr;
    logic              r_trg_req;
    logic [N_BIT-1:0]  r_psnm;
    logic [SCL_W-1:0]  r_n_acc;
    logic [SCL_W-1:0]  r_n_lost;

    logic              w_live;
    logic [N_BIT-1:0]  w_pass;
    logic              w_accept;
    logic              w_lost;

    // Live only when idle and downstream is free; BUSY passes straight through.
    assign w_live   = (r_state == S_IDLE) && !BUSY;
    assign w_accept = w_live && (|w_pass);
    assign w_lost   = (|r_ftdr) && !w_live;

    assign LIVE     = w_live;
    assign TRG_REQ  = r_trg_req;
    assign PSNM     = r_psnm;
    assign N_ACC    = r_n_acc;
    assign N_LOST   = r_n_lost;

    // Stage 1: register the qualified, masked input bits.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ftdr <= '0;
        end else begin
            r_ftdr <= FTD_IN & MASK & {N_BIT{FTD_VLD}};
        end
    end

    // Stage 2: one prescale counter per bit, advancing only on live hits.
    generate
        for (genvar gi = 0; gi < N_BIT; gi++) begin : g_bit
            logic [PS_W-1:0] w_ps;
            logic            w_hit;
            logic            w_wrap;
            logic [PS_W-1:0] r_cnt;

            assign w_ps   = PSCALE[gi*PS_W +: PS_W];
            assign w_hit  = w_live && r_ftdr[gi] && (w_ps != '0);
            // count+1 >= k, widened so a lowered k below the count still wraps
            assign w_wrap = ({1'b0, r_cnt} + (PS_W+1)'(1)) >= {1'b0, w_ps};
            assign w_pass[gi] = w_hit && w_wrap;

            // Prescale counter: clear on CLR, wrap on pass, else count the hit.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_cnt <= '0;
                end else if (CLR) begin
                    r_cnt <= '0;
                end else if (w_hit) begin
                    r_cnt <= w_wrap ? '0 : r_cnt + PS_W'(1);
                end
            end
        end
    endgenerate

    // Trigger handshake FSM: request, wait for ack, then optional dead time.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_dcnt    <= '0;
            r_trg_req <= 1'b0;
            r_psnm    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_REQ;
                        r_trg_req <= 1'b1;
                        r_psnm    <= w_pass;
                    end
                end
                S_REQ: begin
                    if (TRG_ACK) begin
                        r_trg_req <= 1'b0;
                        if (DEADTIME == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DEAD;
                            r_dcnt  <= DEADTIME;
                        end
                    end
                end
                S_DEAD: begin
                    r_dcnt <= r_dcnt - DEAD_W'(1);
                    if (r_dcnt == DEAD_W'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating scalers; CLR overrides any same-cycle increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_n_acc  <= '0;
            r_n_lost <= '0;
        end else if (CLR) begin
            r_n_acc  <= '0;
            r_n_lost <= '0;
        end else begin
            if (w_accept && !(&r_n_acc)) begin
                r_n_acc <= r_n_acc + SCL_W'(1);
            end
            if (w_lost && !(&r_n_lost)) begin
                r_n_lost <= r_n_lost + SCL_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ftd_psnm_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ftd_psnm_gate
//  Description : Self-checking bench for ftd_psnm_gate: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ftd_psnm_gate;

    localparam int N_BIT  = 16;
    localparam int PS_W   = 10;
    localparam int DEAD_W = 8;
    localparam int SCL_W  = 5;
    localparam longint SAT = (64'd1 << SCL_W) - 1;

    logic                  CLK = 1'b0;
    logic                  RST_N = 1'b0;
    logic [N_BIT-1:0]      FTD_IN = '0;
    logic                  FTD_VLD = 1'b0;
    logic [N_BIT-1:0]      MASK = '0;
    logic [N_BIT*PS_W-1:0] PSCALE = '0;
    logic [DEAD_W-1:0]     DEADTIME = '0;
    logic                  BUSY = 1'b0;
    logic                  CLR = 1'b0;
    logic                  TRG_ACK = 1'b0;
    logic                  TRG_REQ;
    logic [N_BIT-1:0]      PSNM;
    logic                  LIVE;
    logic [SCL_W-1:0]      N_ACC;
    logic [SCL_W-1:0]      N_LOST;

    ftd_psnm_gate #(.N_BIT(N_BIT), .PS_W(PS_W), .DEAD_W(DEAD_W), .SCL_W(SCL_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .FTD_IN(FTD_IN), .FTD_VLD(FTD_VLD), .MASK(MASK),
        .PSCALE(PSCALE), .DEADTIME(DEADTIME), .BUSY(BUSY), .CLR(CLR), .TRG_ACK(TRG_ACK),
        .TRG_REQ(TRG_REQ), .PSNM(PSNM), .LIVE(LIVE), .N_ACC(N_ACC), .N_LOST(N_LOST)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ps_of(input int i);
        return int'(PSCALE[i*PS_W +: PS_W]);
    endfunction

    // ---------------- behavioural model ----------------
    // Trigger is "busy" while a request is outstanding or dead cycles remain.
    bit              m_req = 0;
    int              m_dead = 0;
    logic [N_BIT-1:0] m_psnm = '0;
    logic [N_BIT-1:0] m_ftdr = '0;
    longint          m_acc = 0;
    longint          m_lost = 0;
    int              m_hits [N_BIT];
    bit              m_live;
    logic [N_BIT-1:0] m_pass;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_req = 0; m_dead = 0; m_psnm = '0; m_ftdr = '0; m_acc = 0; m_lost = 0;
            for (int i = 0; i < N_BIT; i++) m_hits[i] = 0;
        end else begin
            m_live = !m_req && (m_dead == 0) && !BUSY;
            m_pass = '0;
            if (m_live) begin
                for (int i = 0; i < N_BIT; i++) begin
                    if (m_ftdr[i] && ps_of(i) != 0) begin
                        if (m_hits[i] + 1 >= ps_of(i)) begin
                            m_pass[i] = 1'b1;
                            m_hits[i] = 0;
                        end else begin
                            m_hits[i]++;
                        end
                    end
                end
            end
            if (m_req) begin
                if (TRG_ACK) begin
                    m_req  = 0;
                    m_dead = int'(DEADTIME);
                end
            end else if (m_dead > 0) begin
                m_dead--;
            end else if (m_live && m_pass != 0) begin
                m_req  = 1;
                m_psnm = m_pass;
                m_acc  = (m_acc < SAT) ? m_acc + 1 : SAT;
            end
            if (m_ftdr != 0 && !m_live) m_lost = (m_lost < SAT) ? m_lost + 1 : SAT;
            if (CLR) begin
                m_acc = 0; m_lost = 0;
                for (int i = 0; i < N_BIT; i++) m_hits[i] = 0;
            end
            m_ftdr = FTD_IN & MASK & {N_BIT{FTD_VLD}};
        end
    end

    // Every-cycle comparison of the DUT against the model.
    bit cmp_en = 0;
    always begin
        @(negedge CLK);
        #2;
        if (cmp_en && RST_N) begin
            check("model_trg_req", longint'(TRG_REQ), longint'(m_req));
            check("model_psnm",    longint'(PSNM),    longint'(m_psnm));
            check("model_live",    longint'(LIVE),    longint'(!m_req && m_dead == 0 && !BUSY));
            check("model_n_acc",   longint'(N_ACC),   m_acc);
            check("model_n_lost",  longint'(N_LOST),  m_lost);
        end
    end

    // Ack driver: auto-acks the next cycle, or follows man_ack.
    bit auto_ack = 0;
    bit man_ack  = 0;
    always begin
        @(negedge CLK);
        #1;
        TRG_ACK = auto_ack ? TRG_REQ : man_ack;
    end

    // Request rise monitor for the prescale scenario.
    int              req_rises = 0;
    logic [N_BIT-1:0] last_psnm = '0;
    bit              prev_req = 0;
    always begin
        @(negedge CLK);
        if (TRG_REQ && !prev_req) begin
            req_rises++;
            last_psnm = PSNM;
        end
        prev_req = TRG_REQ;
    end

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        FTD_IN = '0; FTD_VLD = 1'b0; CLR = 1'b0; BUSY = 1'b0;
        auto_ack = 0; man_ack = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic set_ps(input int i, input int v);
        PSCALE[i*PS_W +: PS_W] = PS_W'(v);
    endtask

    task automatic pulse(input logic [N_BIT-1:0] bits);
        @(negedge CLK);
        FTD_IN = bits; FTD_VLD = 1'b1;
        @(negedge CLK);
        FTD_IN = '0; FTD_VLD = 1'b0;
    endtask

    task automatic wait_req(input int maxc, output bit ok);
        ok = 0;
        for (int k = 0; k < maxc; k++) begin
            @(negedge CLK);
            if (TRG_REQ) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic ack_once();
        man_ack = 1;
        @(negedge CLK);
        man_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int rises_seen;
        logic [N_BIT-1:0] held;

        do_reset();
        cmp_en = 1;
        #3;
        check("reset_trg_req", longint'(TRG_REQ), 0);
        check("reset_psnm",    longint'(PSNM), 0);
        check("reset_n_acc",   longint'(N_ACC), 0);
        check("reset_n_lost",  longint'(N_LOST), 0);
        check("reset_live",    longint'(LIVE), 1);

        // T1: prescale 1-of-3 on bit0
        MASK = 16'h0001; PSCALE = '0; set_ps(0, 3); DEADTIME = 0; auto_ack = 1;
        req_rises = 0;
        for (int p = 1; p <= 9; p++) begin
            pulse(16'h0001);
            repeat (8) @(negedge CLK);
            check("t1_req_count", longint'(req_rises), longint'(p / 3));
            if (p % 3 == 0) check("t1_psnm", longint'(last_psnm), 1);
        end
        check("t1_n_acc",  longint'(N_ACC), 3);
        check("t1_n_lost", longint'(N_LOST), 0);

        // T2: everything masked off
        do_reset();
        MASK = '0; set_ps(0, 1); auto_ack = 1; rises_seen = 0;
        @(negedge CLK);
        FTD_IN = '1; FTD_VLD = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (TRG_REQ) rises_seen++;
        end
        FTD_IN = '0; FTD_VLD = 1'b0;
        check("t2_no_req",  longint'(rises_seen), 0);
        check("t2_n_acc",   longint'(N_ACC), 0);
        check("t2_n_lost",  longint'(N_LOST), 0);

        // T3: dead time of 5 cycles
        do_reset();
        MASK = 16'h0001; PSCALE = '0; set_ps(0, 1); DEADTIME = 8'd5;
        pulse(16'h0001);
        wait_req(5, ok);
        check("t3_first_req", longint'(ok), 1);
        ack_once();                       // now half a cycle after the ack edge
        @(negedge CLK);
        pulse(16'h0001);                  // captured 3 cycles after the ack
        @(negedge CLK);
        check("t3_dead_no_req", longint'(TRG_REQ), 0);
        check("t3_n_lost",      longint'(N_LOST), 1);
        pulse(16'h0001);                  // captured 6 cycles after the ack
        @(negedge CLK);
        check("t3_accept_after_dead", longint'(TRG_REQ), 1);
        check("t3_n_acc",             longint'(N_ACC), 2);
        ack_once();
        repeat (8) @(negedge CLK);

        // T4: held handshake while bit2 keeps arriving
        do_reset();
        MASK = '1; PSCALE = '0; set_ps(0, 1); set_ps(2, 3); DEADTIME = 0;
        pulse(16'h0001);
        wait_req(5, ok);
        check("t4_req", longint'(ok), 1);
        held = PSNM;
        check("t4_psnm", longint'(held), 1);
        for (int k = 0; k < 20; k++) begin
            FTD_IN  = (k % 4 == 2 && k < 16) ? 16'h0004 : 16'h0000;
            FTD_VLD = (k % 4 == 2 && k < 16);
            @(negedge CLK);
            check("t4_req_hold",  longint'(TRG_REQ), 1);
            check("t4_psnm_hold", longint'(PSNM), longint'(held));
        end
        FTD_IN = '0; FTD_VLD = 1'b0;
        check("t4_n_lost", longint'(N_LOST), 4);
        ack_once();
        repeat (2) @(negedge CLK);
        pulse(16'h0004);
        pulse(16'h0004);
        repeat (2) @(negedge CLK);
        check("t4_c2_unchanged_no_req", longint'(TRG_REQ), 0);
        pulse(16'h0004);
        @(negedge CLK);
        check("t4_third_hit_req", longint'(TRG_REQ), 1);
        check("t4_third_hit_psnm", longint'(PSNM), 4);
        ack_once();
        repeat (2) @(negedge CLK);

        // T5: asynchronous reset in the middle of a request
        do_reset();
        MASK = 16'h0001; PSCALE = '0; set_ps(0, 1); DEADTIME = 0;
        pulse(16'h0001);
        wait_req(5, ok);
        check("t5_req", longint'(ok), 1);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("t5_async_req",    longint'(TRG_REQ), 0);
        check("t5_async_psnm",   longint'(PSNM), 0);
        check("t5_async_n_acc",  longint'(N_ACC), 0);
        check("t5_async_n_lost", longint'(N_LOST), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        pulse(16'h0001);
        check("t5_after_one_edge", longint'(TRG_REQ), 0);
        @(negedge CLK);
        check("t5_after_two_edges", longint'(TRG_REQ), 1);
        ack_once();
        repeat (2) @(negedge CLK);

        // T6: CLR colliding with an accept, then saturation
        do_reset();
        MASK = 16'h0001; PSCALE = '0; set_ps(0, 1); DEADTIME = 0;
        @(negedge CLK);
        FTD_IN = 16'h0001; FTD_VLD = 1'b1;
        @(negedge CLK);
        FTD_IN = '0; FTD_VLD = 1'b0; CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("t6_clr_req",   longint'(TRG_REQ), 1);
        check("t6_clr_n_acc", longint'(N_ACC), 0);
        ack_once();
        auto_ack = 1;
        for (int k = 0; k < 35; k++) begin
            pulse(16'h0001);
            repeat (3) @(negedge CLK);
        end
        check("t6_acc_saturate", longint'(N_ACC), SAT);
        auto_ack = 0;
        BUSY = 1'b1; FTD_IN = 16'h0001; FTD_VLD = 1'b1;
        repeat (40) @(negedge CLK);
        check("t6_lost_saturate", longint'(N_LOST), SAT);
        CLR = 1'b1; FTD_IN = '0; FTD_VLD = 1'b0;
        @(negedge CLK);
        CLR = 1'b0; BUSY = 1'b0;
        @(negedge CLK);
        check("t6_clr_lost", longint'(N_LOST), 0);
        check("t6_clr_acc",  longint'(N_ACC), 0);

        // Randomized traffic against the model
        do_reset();
        MASK = '1; DEADTIME = 0;
        for (int i = 0; i < N_BIT; i++) set_ps(i, 1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLK);
            FTD_IN  = N_BIT'($urandom & $urandom & $urandom);
            FTD_VLD = ($urandom_range(3) != 0);
            BUSY    = ($urandom_range(7) == 0);
            CLR     = ($urandom_range(150) == 0);
            man_ack = ($urandom_range(2) == 0);
            if (cyc % 97 == 0) DEADTIME = DEAD_W'($urandom_range(6));
            if (cyc % 211 == 0) MASK = N_BIT'($urandom | $urandom);
            if (cyc % 173 == 0)
                for (int i = 0; i < N_BIT; i++) set_ps(i, int'($urandom_range(4)));
        end
        @(negedge CLK);
        FTD_IN = '0; FTD_VLD = 1'b0; BUSY = 1'b0; CLR = 1'b0; man_ack = 1'b0;
        repeat (4) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
